// File: rtl/core_types_pkg.sv
// core_types_pkg: return address stack geometry and shared checkpoint types
package core_types_pkg;
  localparam int RAS_DEPTH = 8;
  localparam int RAS_TARGET_WIDTH = 12;
  localparam int LOG_RAS_DEPTH = $clog2(RAS_DEPTH);
  typedef logic [LOG_RAS_DEPTH-1:0] ras_index_t;
  typedef logic [LOG_RAS_DEPTH:0] ras_count_t;
  typedef logic [RAS_TARGET_WIDTH-1:0] ras_target_t;
endpackage

// File: rtl/ras_stack.sv
// ras_stack: circular return address stack with checkpoint/restore for mispredict repair
//   CLK/RST: clock, synchronous active-high reset
//   push_valid/push_target, pop_valid: predicted call/return updates
//   top_target/top_valid: registered top-of-stack view for fetch
//   ckpt_index/ckpt_count (+ckpt_target): snapshot carried with each prediction
//   restore_valid/restore_index/restore_count (+restore_target): snapshot replay
//   RAS_REPAIR_TOP_EN adds ckpt_target/restore_target to repair a clobbered top entry
module ras_stack
  import core_types_pkg::*;
(
  input  logic        CLK,
  input  logic        RST,
  input  logic        push_valid,
  input  ras_target_t push_target,
  input  logic        pop_valid,
  output ras_target_t top_target,
  output logic        top_valid,
  output ras_index_t  ckpt_index,
  output ras_count_t  ckpt_count,
`ifdef RAS_REPAIR_TOP_EN
  output ras_target_t ckpt_target,
  input  ras_target_t restore_target,
`endif
  input  logic        restore_valid,
  input  ras_index_t  restore_index,
  input  ras_count_t  restore_count
);
  localparam ras_count_t FULL = ras_count_t'(RAS_DEPTH);
  ras_target_t stack [RAS_DEPTH];
  ras_index_t tos;
  ras_count_t count;
  ras_index_t tos_inc;
  ras_index_t tos_dec;
  always_comb begin
    tos_inc = tos + 1'b1;
    tos_dec = tos - 1'b1;
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      tos <= '0;
      count <= '0;
      stack <= '{default: '0};
    end else if (restore_valid) begin
      tos <= restore_index;
      count <= restore_count;
`ifdef RAS_REPAIR_TOP_EN
      stack[restore_index] <= restore_target;
`endif
    end else if (push_valid && pop_valid) begin
      stack[tos] <= push_target;
    end else if (push_valid) begin
      tos <= tos_inc;
      stack[tos_inc] <= push_target;
      count <= (count == FULL) ? count : count + 1'b1;
    end else if (pop_valid) begin
      tos <= tos_dec;
      count <= (count == '0) ? count : count - 1'b1;
    end
  end
  assign top_target = stack[tos];
  assign top_valid = count != '0;
  assign ckpt_index = tos;
  assign ckpt_count = count;
`ifdef RAS_REPAIR_TOP_EN
  assign ckpt_target = stack[tos];
`endif
endmodule

// File: tb/tb_ras_stack.sv
// tb_ras_stack: directed and randomized checks of ras_stack against a queue-free array model
module tb_ras_stack;
  import core_types_pkg::*;
  localparam int D = RAS_DEPTH;
  logic CLK = 0;
  logic RST = 0;
  logic push_valid = 0;
  ras_target_t push_target = '0;
  logic pop_valid = 0;
  ras_target_t top_target;
  logic top_valid;
  ras_index_t ckpt_index;
  ras_count_t ckpt_count;
  logic restore_valid = 0;
  ras_index_t restore_index = '0;
  ras_count_t restore_count = '0;
`ifdef RAS_REPAIR_TOP_EN
  ras_target_t ckpt_target;
  ras_target_t restore_target = '0;
  localparam bit REPAIR = 1;
`else
  localparam bit REPAIR = 0;
`endif
  int n_checks = 0;
  int n_pass = 0;
  int m_tos = 0;
  int m_cnt = 0;
  logic [11:0] m_stk [D];
  ras_stack dut (
    .CLK(CLK), .RST(RST),
    .push_valid(push_valid), .push_target(push_target), .pop_valid(pop_valid),
    .top_target(top_target), .top_valid(top_valid),
    .ckpt_index(ckpt_index), .ckpt_count(ckpt_count),
`ifdef RAS_REPAIR_TOP_EN
    .ckpt_target(ckpt_target), .restore_target(restore_target),
`endif
    .restore_valid(restore_valid), .restore_index(restore_index), .restore_count(restore_count)
  );
  always #5 CLK = ~CLK;
  function automatic logic [19:0] pk(input logic v, input logic [11:0] t, input int i, input int c);
    return {v, t, 3'(i), 4'(c)};
  endfunction
  function automatic logic [19:0] obs();
    return {top_valid, top_target, ckpt_index, ckpt_count};
  endfunction
  function automatic void model(input bit rs, pu, po, rv, input int ri, rc, input logic [11:0] pt, rt);
    if (rs) begin
      m_tos = 0;
      m_cnt = 0;
      foreach (m_stk[i]) m_stk[i] = '0;
    end else if (rv) begin
      m_tos = ri;
      m_cnt = rc;
      if (REPAIR) m_stk[ri] = rt;
    end else if (pu && po) begin
      m_stk[m_tos] = pt;
    end else if (pu) begin
      m_tos = (m_tos + 1) % D;
      m_stk[m_tos] = pt;
      m_cnt = (m_cnt < D) ? m_cnt + 1 : D;
    end else if (po) begin
      m_tos = (m_tos + D - 1) % D;
      m_cnt = (m_cnt > 0) ? m_cnt - 1 : 0;
    end
  endfunction
  task automatic step(input bit rs, pu, po, rv, input int ri, rc, input logic [11:0] pt, rt);
    RST = rs;
    push_valid = pu;
    pop_valid = po;
    push_target = pt;
    restore_valid = rv;
    restore_index = ras_index_t'(ri);
    restore_count = ras_count_t'(rc);
`ifdef RAS_REPAIR_TOP_EN
    restore_target = rt;
`endif
    @(posedge CLK);
    #1;
    model(rs, pu, po, rv, ri, rc, pt, rt);
    RST = 0;
    push_valid = 0;
    pop_valid = 0;
    restore_valid = 0;
  endtask
  task automatic push(input logic [11:0] t);
    step(0, 1, 0, 0, 0, 0, t, 0);
  endtask
  task automatic pop();
    step(0, 0, 1, 0, 0, 0, 0, 0);
  endtask
  task automatic reset();
    step(1, 0, 0, 0, 0, 0, 0, 0);
  endtask
  task automatic test_reset();
    reset();
    reset();
    n_checks++;
    if (obs() !== pk(0, 0, 0, 0)) $display("FAIL reset: got %h want %h", obs(), pk(0, 0, 0, 0));
    else n_pass++;
  endtask
  task automatic test_push_pop();
    reset();
    push(12'h123);
    push(12'h456);
    n_checks++;
    if (obs() !== pk(1, 12'h456, 2, 2)) $display("FAIL push2: got %h want %h", obs(), pk(1, 12'h456, 2, 2));
    else n_pass++;
`ifdef RAS_REPAIR_TOP_EN
    n_checks++;
    if (ckpt_target !== 12'h456) $display("FAIL ckpt_target: got %h want 456", ckpt_target);
    else n_pass++;
`endif
    pop();
    n_checks++;
    if (obs() !== pk(1, 12'h123, 1, 1)) $display("FAIL pop1: got %h want %h", obs(), pk(1, 12'h123, 1, 1));
    else n_pass++;
  endtask
  task automatic test_overflow();
    reset();
    for (int v = 1; v <= 9; v++) push(12'(v));
    n_checks++;
    if (obs() !== pk(1, 9, 1, 8)) $display("FAIL overflow: got %h want %h", obs(), pk(1, 9, 1, 8));
    else n_pass++;
    for (int k = 1; k <= 7; k++) begin
      pop();
      n_checks++;
      if (obs() !== pk(1, 12'(9 - k), (1 - k + D) % D, 8 - k))
        $display("FAIL drain%0d: got %h want %h", k, obs(), pk(1, 12'(9 - k), (1 - k + D) % D, 8 - k));
      else n_pass++;
    end
    pop();
    n_checks++;
    if (obs() !== pk(0, 9, 1, 0)) $display("FAIL empty: got %h want %h", obs(), pk(0, 9, 1, 0));
    else n_pass++;
    pop();
    n_checks++;
    if (obs() !== pk(0, 8, 0, 0)) $display("FAIL underflow: got %h want %h", obs(), pk(0, 8, 0, 0));
    else n_pass++;
  endtask
  task automatic test_swap();
    reset();
    push(12'h123);
    step(0, 1, 1, 0, 0, 0, 12'h777, 0);
    n_checks++;
    if (obs() !== pk(1, 12'h777, 1, 1)) $display("FAIL swap: got %h want %h", obs(), pk(1, 12'h777, 1, 1));
    else n_pass++;
    reset();
    step(0, 1, 1, 0, 0, 0, 12'h0F0, 0);
    n_checks++;
    if (obs() !== pk(0, 12'h0F0, 0, 0)) $display("FAIL swap_empty: got %h want %h", obs(), pk(0, 12'h0F0, 0, 0));
    else n_pass++;
  endtask
  task automatic test_restore();
    reset();
    push(12'h123);
    push(12'h456);
    push(12'hABC);
    pop();
    pop();
    n_checks++;
    if (obs() !== pk(1, 12'h123, 1, 1)) $display("FAIL wrong_path: got %h want %h", obs(), pk(1, 12'h123, 1, 1));
    else n_pass++;
    step(0, 1, 1, 0, 0, 0, 12'hBAD, 0);
    step(0, 0, 0, 1, 2, 2, 0, 12'h456);
    n_checks++;
    if (obs() !== pk(1, 12'h456, 2, 2)) $display("FAIL restore_a: got %h want %h", obs(), pk(1, 12'h456, 2, 2));
    else n_pass++;
    step(0, 0, 0, 1, 1, 1, 0, 12'h123);
    n_checks++;
    if (obs() !== pk(1, REPAIR ? 12'h123 : 12'hBAD, 1, 1))
      $display("FAIL restore_b: got %h want %h", obs(), pk(1, REPAIR ? 12'h123 : 12'hBAD, 1, 1));
    else n_pass++;
  endtask
  task automatic test_priority();
    reset();
    push(12'h011);
    push(12'h022);
    step(0, 1, 1, 1, 5, 3, 12'h333, 12'h0AA);
    n_checks++;
    if (obs() !== pk(1, REPAIR ? 12'h0AA : 12'h000, 5, 3))
      $display("FAIL restore_prio: got %h want %h", obs(), pk(1, REPAIR ? 12'h0AA : 12'h000, 5, 3));
    else n_pass++;
    step(0, 0, 0, 1, 0, 8, 0, 12'h055);
    n_checks++;
    if (obs() !== pk(1, REPAIR ? 12'h055 : 12'h000, 0, 8))
      $display("FAIL restore_full: got %h want %h", obs(), pk(1, REPAIR ? 12'h055 : 12'h000, 0, 8));
    else n_pass++;
    step(1, 1, 0, 1, 6, 4, 12'h444, 12'h066);
    n_checks++;
    if (obs() !== pk(0, 0, 0, 0)) $display("FAIL reset_prio: got %h want %h", obs(), pk(0, 0, 0, 0));
    else n_pass++;
  endtask
  task automatic test_random();
    reset();
    for (int n = 0; n < 400; n++) begin
      int unsigned r = $urandom_range(99);
      step(r < 2, $urandom_range(1) == 1, $urandom_range(1) == 1, r >= 2 && r < 12,
           $urandom_range(D - 1), $urandom_range(D), 12'($urandom), 12'($urandom));
      n_checks++;
      if (obs() !== pk(m_cnt != 0, m_stk[m_tos], m_tos, m_cnt))
        $display("FAIL random%0d: got %h want %h", n, obs(), pk(m_cnt != 0, m_stk[m_tos], m_tos, m_cnt));
      else n_pass++;
    end
  endtask
  initial begin
    foreach (m_stk[i]) m_stk[i] = '0;
    test_reset();
    test_push_pop();
    test_overflow();
    test_swap();
    test_restore();
    test_priority();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
